// File: rtl/alu_coef_sequencer.sv
// alu_coef_sequencer
//   Sequences coefficient pairs from a host-written table into the ALU
//   multiply stage operand registers: b coefficient, then d coefficient,
//   then one cycle flagging that the multiplier outputs reflect that pair.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   cfg_we/cfg_sel/cfg_addr/cfg_data table write (sel 0 = b, 1 = d)
//   cfg_err                         pulse: write dropped while busy
//   start/add_mode/last_idx         run request, sampled only in IDLE
//   abort                           terminate a run (highest priority)
//   busy                            not IDLE
//   b_en/d_en/imm/f_add             operand-register load interface
//   pair_valid/pair_idx/done        pair completion flags
module alu_coef_sequencer #(
  parameter int unsigned BUS_WIDTH = 8,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned ADDR_W    = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_we,
  input  logic                 cfg_sel,
  input  logic [ADDR_W-1:0]    cfg_addr,
  input  logic [BUS_WIDTH-1:0] cfg_data,
  output logic                 cfg_err,
  input  logic                 start,
  input  logic                 add_mode,
  input  logic [ADDR_W-1:0]    last_idx,
  input  logic                 abort,
  output logic                 busy,
  output logic                 b_en,
  output logic                 d_en,
  output logic                 f_add,
  output logic [BUS_WIDTH-1:0] imm,
  output logic                 pair_valid,
  output logic [ADDR_W-1:0]    pair_idx,
  output logic                 done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD_B = 2'd1,
    S_LOAD_D = 2'd2,
    S_VALID  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] ZERO_IDX = '0;

  state_t               r_state;
  logic [BUS_WIDTH-1:0] r_b_tab [DEPTH];
  logic [BUS_WIDTH-1:0] r_d_tab [DEPTH];
  logic [ADDR_W-1:0]    r_idx;
  logic [ADDR_W-1:0]    r_last;
  logic                 r_busy;
  logic                 r_b_en;
  logic                 r_d_en;
  logic                 r_f_add;
  logic [BUS_WIDTH-1:0] r_imm;
  logic                 r_pair_valid;
  logic [ADDR_W-1:0]    r_pair_idx;
  logic                 r_done;
  logic                 r_cfg_err;

  logic                 w_idle;
  logic [ADDR_W-1:0]    w_idx_inc;

  assign w_idle    = (r_state == S_IDLE);
  assign w_idx_inc = r_idx + ADDR_W'(1);

  // Coefficient tables; writes are only accepted while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_b_tab[i] <= '0;
        r_d_tab[i] <= '0;
      end
    end else if (cfg_we && w_idle) begin
      if (cfg_sel) r_d_tab[cfg_addr] <= cfg_data;
      else         r_b_tab[cfg_addr] <= cfg_data;
    end
  end

  // Sequencer FSM; outputs are registered alongside the next state so they
  // show up in the cycle the FSM occupies that state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_last       <= '0;
      r_busy       <= 1'b0;
      r_b_en       <= 1'b0;
      r_d_en       <= 1'b0;
      r_f_add      <= 1'b0;
      r_imm        <= '0;
      r_pair_valid <= 1'b0;
      r_pair_idx   <= '0;
      r_done       <= 1'b0;
      r_cfg_err    <= 1'b0;
    end else begin
      r_b_en       <= 1'b0;
      r_d_en       <= 1'b0;
      r_pair_valid <= 1'b0;
      r_done       <= 1'b0;
      r_cfg_err    <= cfg_we && !w_idle;

      if (!w_idle && abort) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_state <= S_LOAD_B;
              r_busy  <= 1'b1;
              r_f_add <= add_mode;
              r_last  <= last_idx;
              r_idx   <= ZERO_IDX;
              r_b_en  <= 1'b1;
              r_imm   <= add_mode ? '0 : r_b_tab[ZERO_IDX];
            end
          end
          S_LOAD_B: begin
            r_state <= S_LOAD_D;
            r_d_en  <= 1'b1;
            r_imm   <= r_f_add ? '0 : r_d_tab[r_idx];
          end
          S_LOAD_D: begin
            r_state      <= S_VALID;
            r_pair_valid <= 1'b1;
            r_pair_idx   <= r_idx;
            r_done       <= (r_idx == r_last);
          end
          S_VALID: begin
            if (r_idx == r_last) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_LOAD_B;
              r_idx   <= w_idx_inc;
              r_b_en  <= 1'b1;
              r_imm   <= r_f_add ? '0 : r_b_tab[w_idx_inc];
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign cfg_err    = r_cfg_err;
  assign busy       = r_busy;
  assign b_en       = r_b_en;
  assign d_en       = r_d_en;
  assign f_add      = r_f_add;
  assign imm        = r_imm;
  assign pair_valid = r_pair_valid;
  assign pair_idx   = r_pair_idx;
  assign done       = r_done;

endmodule

// File: tb/tb_alu_coef_sequencer.sv
// Directed bench for alu_coef_sequencer. Cycle 0 is the cycle in which
// start is high; outputs are sampled 1 time unit after each rising edge.
module tb_alu_coef_sequencer;

  logic       clk;
  logic       rst_n;
  logic       cfg_we;
  logic       cfg_sel;
  logic [2:0] cfg_addr;
  logic [7:0] cfg_data;
  logic       cfg_err;
  logic       start;
  logic       add_mode;
  logic [2:0] last_idx;
  logic       abort;
  logic       busy;
  logic       b_en;
  logic       d_en;
  logic       f_add;
  logic [7:0] imm;
  logic       pair_valid;
  logic [2:0] pair_idx;
  logic       done;

  int n_vec = 0;
  int n_err = 0;

  alu_coef_sequencer #(.BUS_WIDTH(8), .DEPTH(8), .ADDR_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_err(cfg_err), .start(start), .add_mode(add_mode), .last_idx(last_idx),
    .abort(abort), .busy(busy), .b_en(b_en), .d_en(d_en), .f_add(f_add),
    .imm(imm), .pair_valid(pair_valid), .pair_idx(pair_idx), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cfg(input logic sel, input logic [2:0] addr, input logic [7:0] data);
    cfg_we = 1'b1; cfg_sel = sel; cfg_addr = addr; cfg_data = data;
    tick();
    cfg_we = 1'b0;
  endtask

  // Leaves the bench sampling cycle 1 of the run.
  task automatic do_start(input logic [2:0] last, input logic am);
    start = 1'b1; last_idx = last; add_mode = am;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cfg_we = 0; cfg_sel = 0; cfg_addr = 0; cfg_data = 0;
    start = 0; add_mode = 0; last_idx = 0; abort = 0;
    tick(); tick();
    n_vec++;
    if ({cfg_err, busy, b_en, d_en, f_add, pair_valid, done} !== 7'b0) begin
      $display("FAIL reset_flags: got %b want 0000000", {cfg_err, busy, b_en, d_en, f_add, pair_valid, done});
      n_err++;
    end
    n_vec++;
    if (imm !== 8'h00) begin $display("FAIL reset_imm: got %h want 00", imm); n_err++; end
    n_vec++;
    if (pair_idx !== 3'd0) begin $display("FAIL reset_pair_idx: got %0d want 0", pair_idx); n_err++; end
    @(negedge clk); rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] bx [3];
    logic [7:0] dx [3];
    bx[0] = 8'h10; bx[1] = 8'h20; bx[2] = 8'h30;
    dx[0] = 8'h01; dx[1] = 8'h02; dx[2] = 8'h03;
    for (int i = 0; i < 3; i++) begin
      write_cfg(1'b0, 3'(i), bx[i]);
      write_cfg(1'b1, 3'(i), dx[i]);
    end
    do_start(3'd2, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      int ph;
      int pr;
      logic [4:0] ef;
      logic [7:0] ei;
      ph = (c - 1) % 3;
      pr = (c - 1) / 3;
      if (c == 10) begin ef = 5'b0; ei = 8'h03; end
      else begin
        ef = {1'b1, ph == 0, ph == 1, ph == 2, (ph == 2) && (pr == 2)};
        ei = (ph == 0) ? bx[pr] : dx[pr];
      end
      n_vec++;
      if ({busy, b_en, d_en, pair_valid, done} !== ef) begin
        $display("FAIL basic_flags c%0d: got %b want %b", c, {busy, b_en, d_en, pair_valid, done}, ef);
        n_err++;
      end
      n_vec++;
      if (imm !== ei) begin $display("FAIL basic_imm c%0d: got %h want %h", c, imm, ei); n_err++; end
      if (c < 10 && ph == 2) begin
        n_vec++;
        if (pair_idx !== 3'(pr)) begin
          $display("FAIL basic_pair_idx c%0d: got %0d want %0d", c, pair_idx, pr); n_err++;
        end
      end
      tick();
    end
  endtask

  task automatic test_add_mode();
    do_start(3'd1, 1'b1);
    for (int c = 1; c <= 7; c++) begin
      int ph;
      logic [4:0] ef;
      ph = (c - 1) % 3;
      ef = (c == 7) ? 5'b0 : {1'b1, ph == 0, ph == 1, ph == 2, c == 6};
      n_vec++;
      if ({busy, b_en, d_en, pair_valid, done} !== ef) begin
        $display("FAIL add_flags c%0d: got %b want %b", c, {busy, b_en, d_en, pair_valid, done}, ef);
        n_err++;
      end
      n_vec++;
      if ({f_add, imm} !== {1'b1, 8'h00}) begin
        $display("FAIL add_fadd_imm c%0d: got %b/%h want 1/00", c, f_add, imm); n_err++;
      end
      tick();
    end
  endtask

  task automatic test_abort();
    do_start(3'd2, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    n_vec++;
    if ({d_en, pair_valid, imm} !== {1'b1, 1'b0, 8'h02}) begin
      $display("FAIL abort_pre c5: got d_en=%b pv=%b imm=%h want 1 0 02", d_en, pair_valid, imm); n_err++;
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    for (int c = 6; c <= 8; c++) begin
      n_vec++;
      if ({busy, b_en, d_en, pair_valid, done} !== 5'b0) begin
        $display("FAIL abort_post c%0d: got %b want 00000", c, {busy, b_en, d_en, pair_valid, done});
        n_err++;
      end
      tick();
    end
    do_start(3'd0, 1'b0);
    n_vec++;
    if ({b_en, imm} !== {1'b1, 8'h10}) begin
      $display("FAIL abort_rerun_b c1: got %b/%h want 1/10", b_en, imm); n_err++;
    end
    tick(); tick();
    n_vec++;
    if ({busy, pair_valid, done, pair_idx} !== {3'b111, 3'd0}) begin
      $display("FAIL abort_rerun_done c3: got %b/%0d want 111/0", {busy, pair_valid, done}, pair_idx);
      n_err++;
    end
    tick();
    n_vec++;
    if (busy !== 1'b0) begin $display("FAIL abort_rerun_idle c4: got %b want 0", busy); n_err++; end
  endtask

  task automatic test_cfg_err();
    do_start(3'd1, 1'b0);
    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 3'd0; cfg_data = 8'h55;
    tick();
    cfg_we = 1'b0;
    n_vec++;
    if (cfg_err !== 1'b1) begin $display("FAIL cfg_err_pulse: got %b want 1", cfg_err); n_err++; end
    tick();
    n_vec++;
    if (cfg_err !== 1'b0) begin $display("FAIL cfg_err_clear: got %b want 0", cfg_err); n_err++; end
    for (int i = 0; i < 4; i++) tick();
    n_vec++;
    if (busy !== 1'b0) begin $display("FAIL cfg_run_end: got busy %b want 0", busy); n_err++; end
    do_start(3'd0, 1'b0);
    n_vec++;
    if (imm !== 8'h10) begin $display("FAIL cfg_dropped_write: got %h want 10", imm); n_err++; end
    tick(); tick(); tick();
    write_cfg(1'b0, 3'd0, 8'h55);
    n_vec++;
    if (cfg_err !== 1'b0) begin $display("FAIL cfg_idle_no_err: got %b want 0", cfg_err); n_err++; end
    do_start(3'd0, 1'b0);
    n_vec++;
    if ({b_en, imm} !== {1'b1, 8'h55}) begin
      $display("FAIL cfg_idle_write: got %b/%h want 1/55", b_en, imm); n_err++;
    end
    tick(); tick(); tick();
    // write in the same cycle as an accepted start is still an idle write
    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 3'd1; cfg_data = 8'h66;
    do_start(3'd1, 1'b0);
    cfg_we = 1'b0;
    tick();
    n_vec++;
    if (cfg_err !== 1'b0) begin $display("FAIL cfg_start_write_err: got %b want 0", cfg_err); n_err++; end
    tick(); tick();
    n_vec++;
    if ({b_en, imm} !== {1'b1, 8'h66}) begin
      $display("FAIL cfg_start_write: got %b/%h want 1/66", b_en, imm); n_err++;
    end
    tick(); tick(); tick();
  endtask

  task automatic test_start_ignored();
    do_start(3'd1, 1'b0);
    tick();
    start = 1'b1; last_idx = 3'd7; add_mode = 1'b1;
    tick();
    start = 1'b0;
    n_vec++;
    if ({f_add, pair_valid, pair_idx} !== {1'b0, 1'b1, 3'd0}) begin
      $display("FAIL ign_c3: got %b/%b/%0d want 0/1/0", f_add, pair_valid, pair_idx); n_err++;
    end
    tick(); tick(); tick();
    n_vec++;
    if ({f_add, pair_valid, done, pair_idx} !== {3'b011, 3'd1}) begin
      $display("FAIL ign_done c6: got %b/%0d want 011/1", {f_add, pair_valid, done}, pair_idx); n_err++;
    end
    tick();
    n_vec++;
    if (busy !== 1'b0) begin $display("FAIL ign_idle c7: got %b want 0", busy); n_err++; end
  endtask

  task automatic test_full();
    int npv;
    npv = 0;
    do_start(3'd7, 1'b0);
    for (int c = 1; c <= 25; c++) begin
      if (pair_valid) begin
        npv++;
        n_vec++;
        if (pair_idx !== 3'(c / 3 - 1)) begin
          $display("FAIL full_pair_idx c%0d: got %0d want %0d", c, pair_idx, c / 3 - 1); n_err++;
        end
      end
      n_vec++;
      if (done !== (c == 24)) begin
        $display("FAIL full_done c%0d: got %b want %b", c, done, c == 24); n_err++;
      end
      if (c == 25) begin
        n_vec++;
        if (busy !== 1'b0) begin $display("FAIL full_idle c25: got %b want 0", busy); n_err++; end
      end
      tick();
    end
    n_vec++;
    if (npv != 8) begin $display("FAIL full_pv_count: got %0d want 8", npv); n_err++; end
  endtask

  task automatic test_reset_midrun();
    int nld;
    nld = 0;
    do_start(3'd2, 1'b0);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({cfg_err, busy, b_en, d_en, f_add, pair_valid, done, imm, pair_idx} !== 18'b0) begin
      $display("FAIL midrst_outputs: got %b want all zero",
               {cfg_err, busy, b_en, d_en, f_add, pair_valid, done, imm, pair_idx});
      n_err++;
    end
    @(negedge clk); rst_n = 1'b1;
    tick();
    do_start(3'd7, 1'b0);
    for (int c = 1; c <= 24; c++) begin
      if (b_en || d_en) begin
        nld++;
        n_vec++;
        if (imm !== 8'h00) begin $display("FAIL midrst_imm c%0d: got %h want 00", c, imm); n_err++; end
      end
      tick();
    end
    n_vec++;
    if (nld != 16) begin $display("FAIL midrst_loads: got %0d want 16", nld); n_err++; end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_add_mode();
    test_abort();
    test_cfg_err();
    test_start_ignored();
    test_full();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
